// File: rtl/mac_tx_fcs.sv
`default_nettype none
// mac_tx_fcs: Ethernet MAC TX stage; zero-pads short frames and appends the IEEE 802.3 FCS.
// Revision: 1.0
module mac_tx_fcs #(
  parameter int ENABLE_PADDING = 1,
  parameter int MIN_FRAME_LEN  = 60
) (
  input  logic       clk,
  input  logic       srstb,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_PAD     = 2'd2,
    S_FCS     = 2'd3
  } state_t;

  state_t      state_q;
  logic [31:0] crc_q;
  logic [15:0] byte_cnt_q;
  logic [1:0]  fcs_idx_q;
  logic        err_q;
  logic [7:0]  tdata_q;
  logic        tvalid_q;
  logic        tlast_q;
  logic        tuser_q;

  // Byte-wide CRC-32 step: LSB-first Galois LFSR of 04C11DB7, i.e. the reflected polynomial EDB88320.
  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  logic        w_out_ready;
  logic        w_in_ready;
  logic        w_accept;
  logic [31:0] w_crc_in;
  logic [31:0] w_crc_pad;
  logic [15:0] w_cnt_next;
  logic        w_need_pad;
  logic        w_pad_done;
  logic [31:0] w_fcs;
  logic [7:0]  w_fcs_byte;

  assign w_out_ready = !tvalid_q || m_axis_tready;
  assign w_in_ready  = !srstb && (state_q == S_IDLE || state_q == S_PAYLOAD) && w_out_ready;
  assign w_accept    = s_axis_tvalid && w_in_ready;

  // The first byte of a frame restarts the CRC from all-ones regardless of the stale crc_q.
  assign w_crc_in   = crc_step((state_q == S_IDLE) ? 32'hFFFFFFFF : crc_q, s_axis_tdata);
  assign w_crc_pad  = crc_step(crc_q, 8'h00);
  assign w_cnt_next = (state_q == S_IDLE) ? 16'd1 :
                      (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;
  assign w_need_pad = (ENABLE_PADDING != 0) && ({16'd0, w_cnt_next} < 32'(MIN_FRAME_LEN));
  assign w_pad_done = {16'd0, w_cnt_next} >= 32'(MIN_FRAME_LEN);

  assign w_fcs = ~crc_q;
  always_comb begin
    w_fcs_byte = w_fcs[7:0];
    case (fcs_idx_q)
      2'd0:    w_fcs_byte = w_fcs[7:0];
      2'd1:    w_fcs_byte = w_fcs[15:8];
      2'd2:    w_fcs_byte = w_fcs[23:16];
      default: w_fcs_byte = w_fcs[31:24];
    endcase
  end

  always_ff @(posedge clk) begin
    if (srstb) begin
      state_q    <= S_IDLE;
      crc_q      <= 32'hFFFFFFFF;
      byte_cnt_q <= 16'd0;
      fcs_idx_q  <= 2'd0;
      err_q      <= 1'b0;
      tdata_q    <= 8'd0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tuser_q    <= 1'b0;
    end else begin
      // A consumed output slot empties unless one of the branches below refills it.
      if (w_out_ready) begin
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
        tuser_q  <= 1'b0;
      end
      case (state_q)
        S_IDLE, S_PAYLOAD: begin
          if (state_q == S_IDLE) begin
            byte_cnt_q <= 16'd0;
          end
          if (w_accept) begin
            tdata_q    <= s_axis_tdata;
            tvalid_q   <= 1'b1;
            crc_q      <= w_crc_in;
            byte_cnt_q <= w_cnt_next;
            fcs_idx_q  <= 2'd0;
            if (s_axis_tlast) begin
              err_q   <= s_axis_tuser;
              state_q <= w_need_pad ? S_PAD : S_FCS;
            end else begin
              state_q <= S_PAYLOAD;
            end
          end
        end
        S_PAD: begin
          if (w_out_ready) begin
            tdata_q    <= 8'h00;
            tvalid_q   <= 1'b1;
            crc_q      <= w_crc_pad;
            byte_cnt_q <= w_cnt_next;
            if (w_pad_done) begin
              state_q <= S_FCS;
            end
          end
        end
        default: begin
          if (w_out_ready) begin
            tdata_q   <= w_fcs_byte;
            tvalid_q  <= 1'b1;
            fcs_idx_q <= fcs_idx_q + 2'd1;
            if (fcs_idx_q == 2'd3) begin
              tlast_q <= 1'b1;
              tuser_q <= err_q;
              state_q <= S_IDLE;
            end
          end
        end
      endcase
    end
  end

  assign s_axis_tready = w_in_ready;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_tx_fcs.sv
`default_nettype none
// tb_mac_tx_fcs: scoreboard bench for mac_tx_fcs with a padding and a non-padding instance.
`timescale 1ns/1ps
module tb_mac_tx_fcs;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       srstb = 1'b1;
  logic [7:0] drv_data = 8'd0;
  logic       drv_valid = 1'b0;
  logic       drv_last = 1'b0;
  logic       drv_user = 1'b0;
  logic       sel = 1'b0;
  logic       m_ready = 1'b1;
  logic       rand_ready = 1'b0;

  logic       sa_ready, ma_valid, ma_last, ma_user;
  logic [7:0] ma_data;
  logic       sb_ready, mb_valid, mb_last, mb_user;
  logic [7:0] mb_data;

  logic [9:0] exp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         t_first = -1;
  int         t_last = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mac_tx_fcs #(.ENABLE_PADDING(0), .MIN_FRAME_LEN(60)) u_nopad (
    .clk(clk), .srstb(srstb),
    .s_axis_tdata(drv_data), .s_axis_tvalid(drv_valid && !sel), .s_axis_tready(sa_ready),
    .s_axis_tlast(drv_last), .s_axis_tuser(drv_user),
    .m_axis_tdata(ma_data), .m_axis_tvalid(ma_valid), .m_axis_tready(m_ready),
    .m_axis_tlast(ma_last), .m_axis_tuser(ma_user)
  );

  mac_tx_fcs #(.ENABLE_PADDING(1), .MIN_FRAME_LEN(60)) u_pad (
    .clk(clk), .srstb(srstb),
    .s_axis_tdata(drv_data), .s_axis_tvalid(drv_valid && sel), .s_axis_tready(sb_ready),
    .s_axis_tlast(drv_last), .s_axis_tuser(drv_user),
    .m_axis_tdata(mb_data), .m_axis_tvalid(mb_valid), .m_axis_tready(m_ready),
    .m_axis_tlast(mb_last), .m_axis_tuser(mb_user)
  );

  logic [7:0] mon_data;
  logic       mon_valid, mon_last, mon_user, s_ready;
  assign mon_data  = sel ? mb_data  : ma_data;
  assign mon_valid = sel ? mb_valid : ma_valid;
  assign mon_last  = sel ? mb_last  : ma_last;
  assign mon_user  = sel ? mb_user  : ma_user;
  assign s_ready   = sel ? sb_ready : sa_ready;

  // Reference CRC kept in the non-reflected (MSB-first register) form, fed LSB-first per byte.
  function automatic logic [31:0] ref_crc(input logic [31:0] f, input logic [7:0] b);
    logic [31:0] r;
    logic        fb;
    r = f;
    for (int i = 0; i < 8; i++) begin
      fb = r[31] ^ b[i];
      r  = {r[30:0], 1'b0};
      if (fb) r = r ^ 32'h04C11DB7;
    end
    return r;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  always @(posedge clk) begin
    #1;
    m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'd0;
  logic [31:0] mon_crc = 32'hFFFFFFFF;
  logic [9:0]  e;

  always @(negedge clk) begin
    if (srstb) begin
      prev_stall = 1'b0;
      mon_crc    = 32'hFFFFFFFF;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!(mon_valid && mon_data == prev_data)) begin
          failures++;
          $display("FAIL hold_stable: valid=%0b data=%02h required valid=1 data=%02h",
                   mon_valid, mon_data, prev_data);
        end
      end
      prev_stall = mon_valid && !m_ready;
      prev_data  = mon_data;
      if (mon_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output: data=%02h last=%0b required no output", mon_data, mon_last);
        end else begin
          e = exp_q.pop_front();
          if ({mon_user, mon_last, mon_data} !== e) begin
            failures++;
            $display("FAIL out_byte: user=%0b last=%0b data=%02h required user=%0b last=%0b data=%02h",
                     mon_user, mon_last, mon_data, e[9], e[8], e[7:0]);
          end
          if (t_first < 0) t_first = cyc;
          mon_crc = ref_crc(mon_crc, mon_data);
          if (mon_last) begin
            t_last = cyc;
            checks++;
            if (rev32(mon_crc) !== 32'hDEBB20E3) begin
              failures++;
              $display("FAIL crc_residue: got %08h required DEBB20E3", rev32(mon_crc));
            end
            mon_crc = 32'hFFFFFFFF;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic push_expected(input bq_t bytes, input logic user, input logic pad_en);
    logic [31:0] f;
    logic [31:0] r;
    int          n;
    f = 32'hFFFFFFFF;
    n = 0;
    foreach (bytes[i]) begin
      exp_q.push_back({2'b00, bytes[i]});
      f = ref_crc(f, bytes[i]);
      n++;
    end
    while (pad_en && n < 60) begin
      exp_q.push_back(10'd0);
      f = ref_crc(f, 8'h00);
      n++;
    end
    r = rev32(~f);
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back({(k == 3) ? user : 1'b0, k == 3, r[8*k +: 8]});
    end
  endtask

  task automatic drive_byte(input logic [7:0] d, input logic last, input logic user);
    int   n;
    logic acc;
    n = 0;
    drv_data  = d;
    drv_valid = 1'b1;
    drv_last  = last;
    drv_user  = user;
    do begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 1000);
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL drive_timeout: byte=%02h not accepted, required acceptance", d);
    end
    drv_valid = 1'b0;
    drv_last  = 1'b0;
    drv_user  = 1'b0;
  endtask

  task automatic send_frame(input bq_t bytes, input logic user, input logic with_last);
    foreach (bytes[i]) begin
      drive_byte(bytes[i], with_last && (i == bytes.size() - 1), user);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_test1();
    bq_t d;
    logic [7:0] fcs[4];
    d   = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    fcs = '{8'h26, 8'h39, 8'hF4, 8'hCB};
    sel = 1'b0;
    t_first = -1;
    foreach (d[i]) exp_q.push_back({2'b00, d[i]});
    for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, k == 3, fcs[k]});
    send_frame(d, 1'b0, 1'b1);
    drain();
    chk("t1_span_cycles", 32'(t_last - t_first), 32'd12);
  endtask

  initial begin
    bq_t f1, f2, f3, f4;

    // Reset state on both instances while srstb is held.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_tvalid", {31'd0, ma_valid | mb_valid}, 32'd0);
    chk("rst_m_tlast",  {31'd0, ma_last  | mb_last},  32'd0);
    chk("rst_m_tuser",  {31'd0, ma_user  | mb_user},  32'd0);
    chk("rst_m_tdata",  {24'd0, ma_data  | mb_data},  32'd0);
    chk("rst_s_tready", {31'd0, sa_ready | sb_ready}, 32'd0);
    srstb = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_s_tready", {31'd0, sa_ready & sb_ready}, 32'd1);

    // Test 1: "123456789" without padding.
    run_test1();

    // Test 2: single zero byte padded to 60.
    sel = 1'b1;
    f1 = '{8'h00};
    push_expected(f1, 1'b0, 1'b1);
    send_frame(f1, 1'b0, 1'b1);
    drain();

    // Test 3: 64-byte frame under a random sink.
    for (int i = 0; i < 64; i++) f2.push_back(8'(i * 7 + 3));
    rand_ready = 1'b1;
    push_expected(f2, 1'b0, 1'b1);
    send_frame(f2, 1'b0, 1'b1);
    drain();
    rand_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Test 4: back-to-back 60-byte frames, second flagged.
    for (int i = 0; i < 60; i++) begin
      f3.push_back(8'(i));
      f4.push_back(8'(255 - i));
    end
    t_first = -1;
    push_expected(f3, 1'b0, 1'b1);
    push_expected(f4, 1'b1, 1'b1);
    send_frame(f3, 1'b0, 1'b1);
    send_frame(f4, 1'b1, 1'b1);
    drain();
    chk("t4_span_cycles", 32'(t_last - t_first), 32'd127);

    // Test 5: reset after 20 bytes of an unterminated frame, then a clean frame.
    sel = 1'b0;
    f1.delete();
    for (int i = 0; i < 20; i++) begin
      f1.push_back(8'(8'hA0 + i));
      exp_q.push_back({2'b00, 8'(8'hA0 + i)});
    end
    send_frame(f1, 1'b0, 1'b0);
    drain();
    srstb = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_m_tvalid", {31'd0, ma_valid}, 32'd0);
    chk("t5_s_tready", {31'd0, sa_ready}, 32'd0);
    srstb = 1'b0;
    @(posedge clk);
    #1;
    run_test1();

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
